// File: rtl/sm_dispatch.sv
// Feeder for the state_machine compute core: buffers signed samples in a FIFO,
// runs one start/done transaction per sample and returns results on a valid/ready port.
module sm_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_data,
    output logic               sm_start,
    output logic signed [15:0] sm_x,
    input  logic               sm_done,
    input  logic signed [31:0] sm_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] out_data,
    output logic [15:0]        done_count,
    output logic               timeout_err,
    input  logic               clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic signed [15:0] r_mem [DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic               r_done_q;
    logic [TW-1:0]      r_timer;
    logic               r_sm_start;
    logic signed [15:0] r_sm_x;
    logic               r_out_valid;
    logic signed [31:0] r_out_data;
    logic [15:0]        r_done_count;
    logic               r_timeout_err;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_rise;
    logic w_capture;
    logic w_timeout;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = in_valid && !w_full;
    assign w_rise  = sm_done && !r_done_q;

    assign in_ready    = !w_full;
    assign sm_start    = r_sm_start;
    assign sm_x        = r_sm_x;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign done_count  = r_done_count;
    assign timeout_err = r_timeout_err;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Holding off while a result is pending keeps it from being overwritten.
                if (!w_empty && !r_out_valid) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_rise) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_timer == TMAX) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_done_q      <= 1'b0;
            r_timer       <= '0;
            r_sm_start    <= 1'b0;
            r_sm_x        <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_done_count  <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done_q   <= sm_done;
            r_sm_start <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                r_sm_x   <= r_mem[r_rd_ptr[AW-1:0]];
            end
            if (r_state == S_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_capture) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= sm_y;
                r_done_count <= r_done_count + 16'd1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            // A timeout in the same cycle as clr_err leaves the flag set.
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (clr_err) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sm_dispatch.sv
// Randomised scoreboard bench for sm_dispatch with a behavioural core (y = 3x + 8).
module tb_sm_dispatch;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int CM_NORM = 0;
    localparam int CM_HANG = 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               sm_start;
    logic signed [15:0] sm_x;
    logic               sm_done;
    logic signed [31:0] sm_y;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_data;
    logic [15:0]        done_count;
    logic               timeout_err;
    logic               clr_err;

    always #5 clk = ~clk;

    sm_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sm_start(sm_start), .sm_x(sm_x), .sm_done(sm_done), .sm_y(sm_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done_count(done_count), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          q_in[$];
    int          q_exp[$];
    int          core_mode = CM_NORM;
    int          lat_fix   = 0;
    int          or_mode   = 1;
    int          n_starts  = 0;
    bit          core_busy = 1'b0;
    bit          spur_en   = 1'b0;
    logic [15:0] ref_done;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name, input int waited, input int limit);
        n_checks++;
        n_fail++;
        $display("FAIL %s: waited %0d cycles, limit %0d", name, waited, limit);
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the sample was accepted.
    task automatic push(input int x);
        int n = 0;
        in_valid = 1'b1;
        in_data  = 16'(x);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 500) begin
                bound_fail("push_wait", n, 500);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        forever begin
            @(negedge clk);
            if (q_in.size() == 0 && q_exp.size() == 0 && !out_valid && !core_busy) break;
            n++;
            if (n > 3000) begin
                bound_fail("drain", n, 3000);
                break;
            end
        end
        align();
    endtask

    task automatic wait_start();
        int n = 0;
        forever begin
            @(negedge clk);
            if (sm_start) break;
            n++;
            if (n > 200) begin
                bound_fail("wait_start", n, 200);
                break;
            end
        end
    endtask

    task automatic meas_timeout(output int n);
        wait_start();
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (timeout_err || n > TIMEOUT + 10) break;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_sm_start"}, sm_start, 0);
        chk({tag, "_sm_x"}, sm_x, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_done_count"}, done_count, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    // Behavioural core: latches x on start, answers after a latency with a done pulse/level.
    initial begin
        int cnt;
        int hold;
        int cx;
        cnt = 0; hold = 0; cx = 0;
        sm_done = 1'b0;
        sm_y    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sm_done   = 1'b0;
                core_busy = 1'b0;
                hold      = 0;
            end else begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) sm_done = 1'b0;
                end
                if (!sm_done) sm_y = $urandom;
                if (core_busy && !sm_done) begin
                    if (cnt == 0) begin
                        sm_done   = 1'b1;
                        sm_y      = 3 * cx + 8;
                        hold      = $urandom_range(1, 2);
                        core_busy = 1'b0;
                    end else begin
                        cnt--;
                    end
                end else if (!core_busy && spur_en && core_mode == CM_NORM && !sm_done &&
                             !sm_start && $urandom_range(0, 19) == 0) begin
                    sm_done = 1'b1;
                    hold    = 1;
                end
                if (sm_start && core_mode == CM_NORM) begin
                    core_busy = 1'b1;
                    cx        = int'(sm_x);
                    cnt       = (lat_fix > 0) ? lat_fix : $urandom_range(1, 12);
                end
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit                 prev_start;
        bit                 prev_ov;
        bit                 hold_v;
        logic signed [31:0] hold_d;
        int                 x;
        int                 e;
        prev_start = 0; prev_ov = 0; hold_v = 0; hold_d = '0;
        ref_done = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q_in.delete();
                q_exp.delete();
                ref_done   = '0;
                prev_start = 0;
                prev_ov    = 0;
                hold_v     = 0;
            end else begin
                if (sm_start) begin
                    chk("start_one_cycle", prev_start, 0);
                    chk("start_with_result_pending", out_valid, 0);
                    n_starts++;
                    if (q_in.size() == 0) begin
                        chk("unexpected_start_queue_size", 0, 1);
                    end else begin
                        x = q_in.pop_front();
                        chk("sm_x_order", sm_x, x);
                        if (core_mode != CM_HANG) q_exp.push_back(3 * x + 8);
                    end
                end
                prev_start = sm_start;
                chk("in_ready", in_ready, (q_in.size() < DEPTH) ? 1 : 0);
                if (in_valid && in_ready) q_in.push_back(int'(in_data));
                if (out_valid && !prev_ov) ref_done++;
                if (out_valid && hold_v) chk("out_data_held", out_data, hold_d);
                if (out_valid && out_ready) begin
                    if (q_exp.size() == 0) begin
                        chk("unexpected_output_queue_size", 0, 1);
                    end else begin
                        e = q_exp.pop_front();
                        chk("out_data", out_data, e);
                    end
                    chk("done_count_live", done_count, ref_done);
                    hold_v = 0;
                end else if (out_valid) begin
                    hold_v = 1;
                    hold_d = out_data;
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time %0t, limit %0d", $time, 900000);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        in_valid = 1'b0;
        in_data  = '0;
        clr_err  = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        align();
        check_reset_vals("after_reset");

        // Single sample through a real core.
        lat_fix = 3;
        s0 = n_starts;
        push(10);
        drain();
        chk("t1_starts", n_starts - s0, 1);
        chk("t1_out_data", out_data, 38);
        chk("t1_done_count", done_count, 1);

        // Back-to-back samples, in order.
        lat_fix = 0;
        push(10);
        push(-4);
        drain();
        chk("t2_last_out_data", out_data, -4);
        chk("t2_done_count", done_count, 3);

        // Fill the FIFO behind a slow core.
        lat_fix = 40;
        for (int i = 0; i < DEPTH + 1; i++) push(100 + i);
        @(negedge clk);
        chk("t3_full_in_ready", in_ready, 0);
        align();
        lat_fix = 2;
        drain();
        chk("t3_last_out_data", out_data, 3 * (100 + DEPTH) + 8);
        chk("t3_done_count", done_count, 3 + DEPTH + 1);

        // Back-pressure: second sample must wait for the first result to be taken.
        or_mode = 0;
        s0 = n_starts;
        push(1);
        push(2);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) bound_fail("t4_wait_out_valid", n, 200);
        repeat (10) @(negedge clk);
        chk("t4_only_one_issued", n_starts - s0, 1);
        chk("t4_out_data_pending", out_data, 11);
        align();
        or_mode = 1;
        drain();
        chk("t4_both_issued", n_starts - s0, 2);
        chk("t4_done_count", done_count, 3 + DEPTH + 1 + 2);

        // Randomised traffic with spurious done pulses while idle.
        or_mode = 2;
        lat_fix = 0;
        spur_en = 1'b1;
        push(32767);
        push(-32768);
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) align();
            push(int'($urandom_range(0, 65535)) - 32768);
        end
        or_mode = 1;
        drain();
        spur_en = 1'b0;
        chk("rand_done_count", done_count, 312);
        chk("rand_no_timeout", timeout_err, 0);

        // Core that never answers.
        core_mode = CM_HANG;
        push(7);
        meas_timeout(n);
        chk("t5_timeout_cycles", n, TIMEOUT + 1);
        chk("t5_timeout_err_set", timeout_err, 1);
        align();
        core_mode = CM_NORM;
        lat_fix   = 4;
        push(5);
        drain();
        chk("t5_recover_out_data", out_data, 23);
        chk("t5_recover_done_count", done_count, 313);
        chk("t5_err_sticky", timeout_err, 1);
        clr_err = 1'b1;
        align();
        clr_err = 1'b0;
        chk("t5_err_cleared", timeout_err, 0);

        // Timeout while clr_err is held: the set must win.
        core_mode = CM_HANG;
        clr_err   = 1'b1;
        push(8);
        meas_timeout(n);
        chk("t5_set_wins_cycles", n, TIMEOUT + 1);
        clr_err = 1'b0;
        @(negedge clk);
        chk("t5_set_wins_flag", timeout_err, 1);
        align();

        // Reset while a sample is in flight with more queued.
        push(20);
        push(21);
        push(22);
        wait_start();
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("t6_async_reset");
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        core_mode = CM_NORM;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("t6_no_out_valid", out_valid, 0);
            chk("t6_no_start", sm_start, 0);
        end
        align();
        lat_fix = 2;
        push(3);
        drain();
        chk("t6_after_out_data", out_data, 17);
        chk("t6_after_done_count", done_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
